// File: rtl/inst_fetch.sv
// Instruction-fetch initiator: owns the PC, drives the ROM fetch port and
// buffers {pc, inst} pairs in a small FIFO for decode, with redirect flush.
module inst_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        rom_ce,
  output logic [31:0] rom_addr,
  input  logic [31:0] rom_inst,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        id_valid,
  input  logic        id_ready,
  output logic [31:0] id_pc,
  output logic [31:0] id_inst
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [31:0]   pc_r;
  logic          ce_r;
  logic [63:0]   mem_r [DEPTH];
  logic [AW-1:0] rd_ptr_r;
  logic [AW-1:0] wr_ptr_r;
  logic [CW-1:0] count_r;

  logic          full_s;
  logic          push_s;
  logic          pop_s;
  logic [31:0]   target_s;

  assign full_s   = (count_r == CW'(DEPTH));
  assign target_s = redirect_pc & 32'hFFFF_FFFC;

  // Fetch enable never looks at id_ready, so ready has no combinational path to ce.
  assign rom_ce   = ce_r & ~full_s;
  assign rom_addr = pc_r;
  assign push_s   = rom_ce & ~redirect_valid;
  assign pop_s    = id_valid & id_ready & ~redirect_valid;

  assign id_valid = (count_r != {CW{1'b0}});
  assign id_pc    = mem_r[rd_ptr_r][63:32];
  assign id_inst  = mem_r[rd_ptr_r][31:0];

  // PC, fetch enable and FIFO state; redirect flushes and outranks push/pop.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc_r     <= RESET_PC & 32'hFFFF_FFFC;
      ce_r     <= 1'b0;
      rd_ptr_r <= {AW{1'b0}};
      wr_ptr_r <= {AW{1'b0}};
      count_r  <= {CW{1'b0}};
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= 64'd0;
      end
    end else begin
      ce_r <= 1'b1;
      if (redirect_valid) begin
        pc_r     <= target_s;
        rd_ptr_r <= {AW{1'b0}};
        wr_ptr_r <= {AW{1'b0}};
        count_r  <= {CW{1'b0}};
      end else begin
        if (push_s) begin
          mem_r[wr_ptr_r] <= {pc_r, rom_inst};
          wr_ptr_r        <= wr_ptr_r + AW'(1);
          pc_r            <= pc_r + 32'd4;
        end else begin
          pc_r <= pc_r;
        end
        if (pop_s) begin
          rd_ptr_r <= rd_ptr_r + AW'(1);
        end else begin
          rd_ptr_r <= rd_ptr_r;
        end
        case ({push_s, pop_s})
          2'b10:   count_r <= count_r + CW'(1);
          2'b01:   count_r <= count_r - CW'(1);
          default: count_r <= count_r;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_inst_fetch.sv
// Directed self-checking bench for inst_fetch: stream, backpressure, reset,
// redirect (while full, with release pop, back-to-back) and PC wrap.
module tb_inst_fetch;

  logic        clk;
  logic        rst_n;
  logic        rom_ce;
  logic [31:0] rom_addr;
  logic [31:0] rom_inst;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        id_valid;
  logic        id_ready;
  logic [31:0] id_pc;
  logic [31:0] id_inst;

  int n_tests = 0;
  int n_fail  = 0;

  inst_fetch #(.RESET_PC(32'h0000_0000), .DEPTH(2)) dut (
    .clk(clk), .rst_n(rst_n), .rom_ce(rom_ce), .rom_addr(rom_addr),
    .rom_inst(rom_inst), .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc), .id_valid(id_valid), .id_ready(id_ready),
    .id_pc(id_pc), .id_inst(id_inst)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ROM word i holds 32'h1000_0000 + i; reads 0 when disabled.
  assign rom_inst = rom_ce ? (32'h1000_0000 + (rom_addr >> 2)) : 32'd0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n          = 1'b0;
    id_ready       = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = 32'd0;
    step();
    step();
    check_eq("rst_ce",    {31'd0, rom_ce},   32'd0);
    check_eq("rst_addr",  rom_addr,          32'd0);
    check_eq("rst_valid", {31'd0, id_valid}, 32'd0);
    check_eq("rst_pc",    id_pc,             32'd0);
    check_eq("rst_inst",  id_inst,           32'd0);

    // Reset release and streaming with id_ready=1
    rst_n = 1'b1;
    step();  // E0
    check_eq("e0_ce",    {31'd0, rom_ce},   32'd1);
    check_eq("e0_addr",  rom_addr,          32'd0);
    check_eq("e0_valid", {31'd0, id_valid}, 32'd0);
    for (int k = 0; k < 5; k++) begin
      step();
      check_eq("str_valid", {31'd0, id_valid}, 32'd1);
      check_eq("str_pc",    id_pc,   32'd4 * k);
      check_eq("str_inst",  id_inst, 32'h1000_0000 + k);
      check_eq("str_addr",  rom_addr, 32'd4 * (k + 1));
    end
    // head 16, fetching 20, count 1

    // Stall: fills to 2, fetch stops
    id_ready = 1'b0;
    step();
    step();
    check_eq("stall_ce",   {31'd0, rom_ce}, 32'd0);
    check_eq("stall_addr", rom_addr, 32'd24);
    check_eq("stall_pc",   id_pc,    32'd16);

    // Reset mid-stream with count=2
    rst_n = 1'b0;
    step();
    check_eq("mrst_ce",    {31'd0, rom_ce},   32'd0);
    check_eq("mrst_valid", {31'd0, id_valid}, 32'd0);
    check_eq("mrst_addr",  rom_addr,          32'd0);
    rst_n = 1'b1;
    step();  // E0
    check_eq("mrst_e0_ce", {31'd0, rom_ce}, 32'd1);
    step();  // push 0
    check_eq("mrst_e1_valid", {31'd0, id_valid}, 32'd1);
    check_eq("mrst_e1_pc",    id_pc,    32'd0);
    check_eq("mrst_e1_addr",  rom_addr, 32'd4);
    step();  // push 4 -> full
    for (int k = 0; k < 3; k++) begin
      check_eq("bp_ce",   {31'd0, rom_ce}, 32'd0);
      check_eq("bp_addr", rom_addr, 32'd8);
      check_eq("bp_pc",   id_pc,    32'd0);
      check_eq("bp_inst", id_inst,  32'h1000_0000);
      step();
    end

    // Release: pop frees a slot, fetch resumes next cycle, no gaps
    id_ready = 1'b1;
    step();
    check_eq("rel_ce",   {31'd0, rom_ce}, 32'd1);
    check_eq("rel_pc",   id_pc,    32'd4);
    check_eq("rel_addr", rom_addr, 32'd8);
    for (int k = 0; k < 3; k++) begin
      step();
      check_eq("rel_seq", id_pc, 32'd8 + 32'd4 * k);
    end
    // head 16, fetching 20, count 1

    // Redirect while full, with id_ready=1
    id_ready = 1'b0;
    step();
    check_eq("full_ce", {31'd0, rom_ce}, 32'd0);
    id_ready       = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0043;
    step();
    redirect_valid = 1'b0;
    check_eq("rdf_valid", {31'd0, id_valid}, 32'd0);
    check_eq("rdf_addr",  rom_addr, 32'h0000_0040);
    step();
    check_eq("rdf_pc",    id_pc,   32'h0000_0040);
    check_eq("rdf_inst",  id_inst, 32'h1000_0010);
    // head 40, fetching 44, count 1

    // Redirect coincident with a full-release pop
    id_ready = 1'b0;
    step();
    id_ready       = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0100;
    step();
    redirect_valid = 1'b0;
    check_eq("rdp_valid", {31'd0, id_valid}, 32'd0);
    check_eq("rdp_addr",  rom_addr, 32'h0000_0100);
    step();
    check_eq("rdp_pc0", id_pc, 32'h0000_0100);
    step();
    check_eq("rdp_pc1", id_pc, 32'h0000_0104);

    // Back-to-back redirects: last wins
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0200;
    step();
    redirect_pc    = 32'h0000_0301;
    step();
    redirect_valid = 1'b0;
    check_eq("b2b_addr",  rom_addr, 32'h0000_0300);
    check_eq("b2b_valid", {31'd0, id_valid}, 32'd0);
    step();
    check_eq("b2b_pc", id_pc, 32'h0000_0300);

    // PC wrap-around
    redirect_valid = 1'b1;
    redirect_pc    = 32'hFFFF_FFF8;
    step();
    redirect_valid = 1'b0;
    check_eq("wrap_addr", rom_addr, 32'hFFFF_FFF8);
    step();
    check_eq("wrap_pc0", id_pc, 32'hFFFF_FFF8);
    step();
    check_eq("wrap_pc1", id_pc, 32'hFFFF_FFFC);
    step();
    check_eq("wrap_pc2", id_pc, 32'h0000_0000);
    check_eq("wrap_inst2", id_inst, 32'h1000_0000);
    step();
    check_eq("wrap_pc3", id_pc, 32'h0000_0004);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/inst_fetch.md
# inst_fetch

Instruction-fetch initiator for the core. It owns the program counter and drives the instruction ROM's `ce`/`addr` fetch port, capturing each instruction in the same cycle as its address. Fetched {pc, inst} pairs go into a small FIFO and are handed to the decode stage over a valid/ready handshake. A branch/jump redirect flushes the FIFO and restarts fetch at the new PC.

## Interface

Parameters:
- `RESET_PC`, 32'h0000_0000: first fetch address after reset; bits [1:0] are always 0.
- `DEPTH`, 2: FIFO entries; a power of two, at least 2.

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst_n`  in  1  reset; synchronous, active-low.
- `rom_ce`  out  1  ROM chip enable.
- `rom_addr`  out  32  byte address to the ROM; equals the current PC.
- `rom_inst`  in  32  ROM read data; combinational from `rom_addr` in the same cycle; 0 when `rom_ce`=0.
- `redirect_valid`  in  1  one-cycle redirect request from execute.
- `redirect_pc`  in  32  redirect target; bits [1:0] are ignored and forced to 0.
- `id_valid`  out  1  FIFO head is valid.
- `id_ready`  in  1  decode accepts the head.
- `id_pc`  out  32  PC of the head entry.
- `id_inst`  out  32  instruction of the head entry.

## Operation

- State:
  - `pc` (32 bits).
  - `ce_q`, the fetch-enable flag.
  - FIFO: DEPTH × 64-bit storage, read pointer, write pointer, count (log2(DEPTH)+1 bits).
- Reset (`rst_n`=0 at an edge):
  - `pc`←RESET_PC, `ce_q`←0.
  - Pointers and count ← 0; storage ← 0.
  - Reset wins over every other input, including during a pending redirect or a full FIFO.
- `rom_ce` = `ce_q` & (count < DEPTH). It does not depend on `id_ready`, so there is no combinational path from ready to ce.
- `rom_addr` = `pc` at all times.
- `ce_q` becomes 1 at the first edge with `rst_n`=1 and stays 1 until the next reset.
- Push: `rom_ce`=1 and `redirect_valid`=0 at an edge. Then {`pc`, `rom_inst`} is written at the write pointer, the write pointer advances, and `pc`←`pc`+4. Addition is modulo 2^32, so 32'hFFFF_FFFC wraps to 0.
- Pop: `id_valid`=1, `id_ready`=1 and `redirect_valid`=0 at an edge. The read pointer advances.
- Simultaneous push and pop: count is unchanged. Otherwise count goes +1 on a push and −1 on a pop.
- Full (count=DEPTH): `rom_ce`=0, `pc` holds, no push. A pop in the same cycle frees a slot; fetch resumes the next cycle.
- Empty (count=0): `id_valid`=0; `id_ready` is ignored.
- Redirect (`redirect_valid`=1 at an edge) has priority over push and pop:
  - Pointers and count ← 0, discarding all entries, including the head even if `id_ready`=1.
  - `pc`←{`redirect_pc`[31:2], 2'b00}.
  - The `rom_inst` captured that cycle is discarded.
- Outputs:
  - `id_valid` = (count ≠ 0).
  - `id_pc`/`id_inst` = storage at the read pointer; they hold stable while `id_valid`=1 and `id_ready`=0.
- Reset values: `rom_ce`=0, `rom_addr`=RESET_PC, `id_valid`=0, `id_pc`=0, `id_inst`=0.

## Timing

- Edge E0 is the first edge with `rst_n`=1.
- Cycle after E0: `rom_ce`=1, `rom_addr`=RESET_PC.
- At E1 the entry is pushed. In the cycle after E1: `id_valid`=1, `id_pc`=RESET_PC, `rom_addr`=RESET_PC+4.
- Fetch-to-decode latency is 1 cycle (address cycle → head visible next cycle).
- With DEPTH≥2 and `id_ready` held at 1, throughput is 1 instruction/cycle with count steady at 1.
- Redirect at edge E:
  - Next cycle: `id_valid`=0, `rom_addr`=target.
  - Cycle after E+1: head = target.
  - Redirect-to-first-valid delay is 2 cycles.
- A redirect asserted on back-to-back cycles: the last one wins.
- Release from full: a pop at edge E gives `rom_ce`=1 in the cycle after E.

## Test plan

- Reset release with ROM word i = 32'h1000_0000+i and `id_ready`=1: after E0, `id_valid` rises one cycle after `rom_ce` and `id_pc` sequences 0,4,8,… every cycle. `id_inst`=32'h1000_0000, 32'h1000_0001, ….
- Backpressure: hold `id_ready`=0 for 5 cycles. `rom_ce` drops once count=2 and `rom_addr` holds 8. `id_pc`=0 stays stable. On releasing `id_ready`, entries pc 0, 4, 8, … are delivered with no gaps or duplicates.
- Redirect with `redirect_pc`=32'h0000_0043 while full and `id_ready`=1: no pop is counted. Next cycle `id_valid`=0 and `rom_addr`=32'h40. Two cycles later `id_pc`=32'h40.
- Wrap-around: redirect to 32'hFFFF_FFF8 yields `id_pc` FFFF_FFF8, FFFF_FFFC, 0000_0000, 0000_0004.
- Reset mid-stream (`rst_n`=0 for 1 cycle with count=2): next cycle `rom_ce`=0, `id_valid`=0, `rom_addr`=RESET_PC. The sequence restarts from RESET_PC as in the first test.
- Redirect coincident with a FIFO-full release pop: the redirect wins and the popped entry is not re-presented. The first valid after the redirect is the target PC.
